// File: rtl/pwm_cap_pkg.sv
// Shared constants for the three-phase PWM duty-cycle capture unit.
// Optional shoot-through checking is enabled with PWM_CAP_SHOOT_CHECK_EN.
package pwm_cap_pkg;
   localparam int CNT_W_DEF     = 16;
   localparam int FAULT_CYC_DEF = 4;
   localparam int SYNC_STAGES   = 2;

   localparam int PH_A = 0;
   localparam int PH_B = 1;
   localparam int PH_C = 2;
endpackage

// File: rtl/pwm_capture_ch.sv
// One capture channel: synchronizer, rise detect, period/high counters, arm/stuck.
// Shoot-through counter on the complementary leg exists only with PWM_CAP_SHOOT_CHECK_EN.
module pwm_capture_ch
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int FAULT_CYC = FAULT_CYC_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pwm,
`ifdef PWM_CAP_SHOOT_CHECK_EN
   input  logic             i_pwm_n,
`endif
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_stuck,
   output logic             o_fault
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sd;
   logic                   r_rise;
   logic                   r_lvl;
   logic                   r_armed;
   logic [CNT_W-1:0]       r_pcnt;
   logic [CNT_W-1:0]       r_hcnt;
   logic                   w_s2;

   assign w_s2 = r_sync[SYNC_STAGES-1];

   // Rise and level are registered once more so results land 3 clks after the input edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync   <= '0;
         r_sd     <= 1'b0;
         r_rise   <= 1'b0;
         r_lvl    <= 1'b0;
         r_armed  <= 1'b0;
         r_pcnt   <= '0;
         r_hcnt   <= '0;
         o_period <= '0;
         o_high   <= '0;
         o_valid  <= 1'b0;
         o_stuck  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
         r_sd    <= w_s2;
         r_rise  <= w_s2 & ~r_sd;
         r_lvl   <= w_s2;
         o_valid <= 1'b0;
         if (r_rise) begin
            if (r_armed && !o_stuck) begin
               o_period <= r_pcnt;
               o_high   <= r_hcnt;
               o_valid  <= 1'b1;
            end
            r_pcnt  <= CNT_W'(1);
            r_hcnt  <= CNT_W'(1);
            r_armed <= 1'b1;
            o_stuck <= 1'b0;
         end else begin
            if (r_pcnt != CNT_MAX)
               r_pcnt <= r_pcnt + CNT_W'(1);
            if (r_lvl && (r_hcnt != CNT_MAX))
               r_hcnt <= r_hcnt + CNT_W'(1);
            // A period that hits the counter ceiling is truncated; never report it.
            if (r_pcnt == CNT_PRE) begin
               o_stuck <= 1'b1;
               r_armed <= 1'b0;
            end
         end
      end
   end

`ifdef PWM_CAP_SHOOT_CHECK_EN
   localparam int FW = $clog2(FAULT_CYC + 1);

   logic [SYNC_STAGES-1:0] r_sync_n;
   logic [FW-1:0]          r_ovl;
   logic                   w_s2n;

   assign w_s2n = r_sync_n[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync_n <= '0;
         r_ovl    <= '0;
         o_fault  <= 1'b0;
      end else begin
         r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], i_pwm_n};
         if (w_s2 && w_s2n) begin
            if (r_ovl != FW'(FAULT_CYC))
               r_ovl <= r_ovl + FW'(1);
            if (r_ovl == FW'(FAULT_CYC - 1))
               o_fault <= 1'b1;
         end else begin
            r_ovl <= '0;
         end
      end
   end
`else
   // Fault checking compiled out; the term keeps FAULT_CYC referenced.
   assign o_fault = 1'b0 & (FAULT_CYC == 0);
`endif

endmodule

// File: rtl/pwm_duty_capture.sv
// Three-phase PWM duty-cycle capture: three independent pwm_capture_ch channels.
// Define PWM_CAP_SHOOT_CHECK_EN to add the complementary inputs and shoot-through faults.
module pwm_duty_capture
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int FAULT_CYC = FAULT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_a,
   input  logic             pwm_b,
   input  logic             pwm_c,
`ifdef PWM_CAP_SHOOT_CHECK_EN
   input  logic             pwm_an,
   input  logic             pwm_bn,
   input  logic             pwm_cn,
`endif
   output logic [CNT_W-1:0] period_a,
   output logic [CNT_W-1:0] period_b,
   output logic [CNT_W-1:0] period_c,
   output logic [CNT_W-1:0] high_a,
   output logic [CNT_W-1:0] high_b,
   output logic [CNT_W-1:0] high_c,
   output logic [2:0]       valid,
   output logic [2:0]       stuck,
   output logic [2:0]       fault
);

   logic [2:0]       w_pwm;
   logic [CNT_W-1:0] w_period [3];
   logic [CNT_W-1:0] w_high   [3];
   logic [2:0]       w_valid;
   logic [2:0]       w_stuck;
   logic [2:0]       w_fault;

   assign w_pwm = {pwm_c, pwm_b, pwm_a};

`ifdef PWM_CAP_SHOOT_CHECK_EN
   logic [2:0] w_pwm_n;
   assign w_pwm_n = {pwm_cn, pwm_bn, pwm_an};
`endif

   for (genvar g = 0; g < 3; g++) begin : g_ch
      pwm_capture_ch #(
         .CNT_W     (CNT_W),
         .FAULT_CYC (FAULT_CYC)
      ) u_ch (
         .i_clk    (clk),
         .i_rst    (rst),
         .i_pwm    (w_pwm[g]),
`ifdef PWM_CAP_SHOOT_CHECK_EN
         .i_pwm_n  (w_pwm_n[g]),
`endif
         .o_period (w_period[g]),
         .o_high   (w_high[g]),
         .o_valid  (w_valid[g]),
         .o_stuck  (w_stuck[g]),
         .o_fault  (w_fault[g])
      );
   end

   assign period_a = w_period[PH_A];
   assign period_b = w_period[PH_B];
   assign period_c = w_period[PH_C];
   assign high_a   = w_high[PH_A];
   assign high_b   = w_high[PH_B];
   assign high_c   = w_high[PH_C];
   assign valid    = w_valid;
   assign stuck    = w_stuck;
   assign fault    = w_fault;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture (CNT_W = 8) with a timestamp-based reference model.
// Covers the shoot-through checks when PWM_CAP_SHOOT_CHECK_EN is defined.
module tb_pwm_duty_capture;
   localparam int CW   = 8;
   localparam int FC   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    pwm = 3'b000;
   logic [2:0]    pwm_n = 3'b000;
   logic [CW-1:0] period_a, period_b, period_c, high_a, high_b, high_c;
   logic [2:0]    valid, stuck, fault;
   logic [CW-1:0] d_per [3];
   logic [CW-1:0] d_hi  [3];

   int n_chk = 0;
   int n_fail = 0;

   int gper [3];
   int ghigh[3];
   int gcnt [3];
   bit gen_en[3];
   bit gconst[3];

   // reference model state: sample history, rise timestamps, expectations
   bit h [3][4];
   bit hn[3][4];
   int n_edge;
   int last_r[3];
   bit have[3];
   int hsum[3];
   int run[3];
   bit e_valid[3];
   bit e_stuck[3];
   bit e_fault[3];
   int e_per[3];
   int e_hi[3];

   pwm_duty_capture #(.CNT_W(CW), .FAULT_CYC(FC)) dut (
      .clk      (clk),
      .rst      (rst),
      .pwm_a    (pwm[0]),
      .pwm_b    (pwm[1]),
      .pwm_c    (pwm[2]),
`ifdef PWM_CAP_SHOOT_CHECK_EN
      .pwm_an   (pwm_n[0]),
      .pwm_bn   (pwm_n[1]),
      .pwm_cn   (pwm_n[2]),
`endif
      .period_a (period_a),
      .period_b (period_b),
      .period_c (period_c),
      .high_a   (high_a),
      .high_b   (high_b),
      .high_c   (high_c),
      .valid    (valid),
      .stuck    (stuck),
      .fault    (fault)
   );

   assign d_per[0] = period_a;
   assign d_per[1] = period_b;
   assign d_per[2] = period_c;
   assign d_hi[0]  = high_a;
   assign d_hi[1]  = high_b;
   assign d_hi[2]  = high_c;

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 40)
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic set_phase(input int p, input int per, input int hi);
      gper[p]   = per;
      ghigh[p]  = hi;
      gcnt[p]   = 0;
      gen_en[p] = 1'b1;
   endtask

   task automatic all_off();
      for (int p = 0; p < 3; p++) begin
         gen_en[p] = 1'b0;
         gconst[p] = 1'b0;
      end
   endtask

   task automatic wait_valid(input string nm, input logic [2:0] mask, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(posedge clk);
         #1;
         if ((valid & mask) == mask) hit = 1'b1;
      end
      check(nm, {31'd0, hit}, 32'd1);
   endtask

   // PWM pattern generator, updates inputs on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         for (int p = 0; p < 3; p++) begin
            if (gen_en[p]) begin
               pwm[p]  = (gcnt[p] < ghigh[p]);
               gcnt[p] = (gcnt[p] + 1 >= gper[p]) ? 0 : gcnt[p] + 1;
            end else begin
               pwm[p] = gconst[p];
            end
         end
      end
   end

   // Reference model: an input sampled at edge m is seen by the measurement at edge m+3
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            n_edge = 0;
            for (int p = 0; p < 3; p++) begin
               for (int j = 0; j < 4; j++) begin
                  h[p][j]  = 1'b0;
                  hn[p][j] = 1'b0;
               end
               last_r[p] = 0; have[p] = 1'b0; hsum[p] = 0; run[p] = 0;
               e_valid[p] = 1'b0; e_stuck[p] = 1'b0; e_fault[p] = 1'b0;
               e_per[p] = 0; e_hi[p] = 0;
            end
         end else begin
            for (int p = 0; p < 3; p++) begin
               e_valid[p] = 1'b0;
               if (h[p][2] && !h[p][3]) begin
                  if (have[p] && (n_edge - last_r[p] <= MAXC - 1)) begin
                     e_valid[p] = 1'b1;
                     e_per[p]   = n_edge - last_r[p];
                     e_hi[p]    = hsum[p];
                  end
                  have[p]    = 1'b1;
                  last_r[p]  = n_edge;
                  hsum[p]    = 1;
                  e_stuck[p] = 1'b0;
               end else begin
                  if (h[p][2] && hsum[p] < MAXC) hsum[p]++;
                  if (n_edge - last_r[p] >= MAXC - 1) e_stuck[p] = 1'b1;
               end
`ifdef PWM_CAP_SHOOT_CHECK_EN
               if (h[p][1] && hn[p][1]) begin
                  run[p]++;
                  if (run[p] >= FC) e_fault[p] = 1'b1;
               end else begin
                  run[p] = 0;
               end
`endif
               for (int j = 3; j > 0; j--) begin
                  h[p][j]  = h[p][j-1];
                  hn[p][j] = hn[p][j-1];
               end
               h[p][0]  = pwm[p];
               hn[p][0] = pwm_n[p];
            end
            n_edge++;
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < 3; p++) begin
            check($sformatf("cmp_valid%0d", p),  {31'd0, valid[p]}, {31'd0, e_valid[p]});
            check($sformatf("cmp_stuck%0d", p),  {31'd0, stuck[p]}, {31'd0, e_stuck[p]});
            check($sformatf("cmp_fault%0d", p),  {31'd0, fault[p]}, {31'd0, e_fault[p]});
            check($sformatf("cmp_period%0d", p), {24'd0, d_per[p]}, e_per[p]);
            check($sformatf("cmp_high%0d", p),   {24'd0, d_hi[p]},  e_hi[p]);
         end
      end
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      all_off();
      repeat (3) @(posedge clk);
      #2;
      check("rst_period_a", {24'd0, period_a}, 0);
      check("rst_valid", {29'd0, valid}, 0);
      check("rst_stuck", {29'd0, stuck}, 0);
      rst = 1'b0;

      // A at 100/30: first rise only arms, strobe lands 3 clks after the second rise
      @(posedge clk); #2;
      set_phase(0, 100, 30);
      repeat (103) @(posedge clk);
      #1;
      check("t1_no_early", {31'd0, valid[0]}, 0);
      @(posedge clk); #1;
      check("t1_valid", {31'd0, valid[0]}, 1);
      check("t1_period", {24'd0, period_a}, 100);
      check("t1_high", {24'd0, high_a}, 30);
      repeat (300) @(posedge clk);

      // Aligned edges on all three phases
      #2; all_off();
      repeat (10) @(posedge clk);
      #2;
      set_phase(0, 200, 50);
      set_phase(1, 200, 100);
      set_phase(2, 200, 150);
      wait_valid("t2_wait", 3'b111, 500);
      check("t2_valid", {29'd0, valid}, 7);
      check("t2_per_a", {24'd0, period_a}, 200);
      check("t2_hi_a", {24'd0, high_a}, 50);
      check("t2_hi_b", {24'd0, high_b}, 100);
      check("t2_per_c", {24'd0, period_c}, 200);
      check("t2_hi_c", {24'd0, high_c}, 150);

      // B held low long enough to saturate
      #1; gen_en[1] = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      check("t3_stuck", {31'd0, stuck[1]}, 1);
      check("t3_per_hold", {24'd0, period_b}, 200);
      check("t3_hi_hold", {24'd0, high_b}, 100);
      #1; set_phase(1, 200, 100);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         @(posedge clk); #1;
         if (!stuck[1]) hit = 1'b1;
      end
      check("t3_unstuck", {31'd0, hit}, 1);
      check("t3_no_strobe", {31'd0, valid[1]}, 0);
      wait_valid("t3_wait", 3'b010, 400);
      check("t3_per", {24'd0, period_b}, 200);
      check("t3_hi", {24'd0, high_b}, 100);

      // Reset in the middle of a period
      #1; all_off();
      repeat (10) @(posedge clk);
      #2; set_phase(0, 100, 30);
      repeat (150) @(posedge clk);
      #2; rst = 1'b1;
      #1;
      check("t4_per0", {24'd0, period_a}, 0);
      check("t4_hi0", {24'd0, high_a}, 0);
      check("t4_valid0", {29'd0, valid}, 0);
      check("t4_stuck0", {29'd0, stuck}, 0);
      repeat (3) @(posedge clk);
      #2; rst = 1'b0;
      wait_valid("t4_wait", 3'b001, 400);
      check("t4_per", {24'd0, period_a}, 100);
      check("t4_hi", {24'd0, high_a}, 30);

      // Randomized periods and duties, some long enough to go stuck
      for (int r = 0; r < 6; r++) begin
         #1;
         for (int p = 0; p < 3; p++) begin
            int per;
            per = $urandom_range(300, 4);
            set_phase(p, per, $urandom_range(per - 1, 1));
            gcnt[p] = $urandom_range(per - 1, 0);
         end
         repeat (800) @(posedge clk);
      end

`ifdef PWM_CAP_SHOOT_CHECK_EN
      #2; all_off();
      gconst[0] = 1'b1;
      pwm_n[0] = 1'b1;
      repeat (3) @(posedge clk);
      #2; pwm_n[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1; check("sh_3clk", {29'd0, fault}, 0);
      #1; pwm_n[0] = 1'b1;
      repeat (4) @(posedge clk);
      #2; pwm_n[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1; check("sh_4clk", {29'd0, fault}, 1);
      repeat (10) @(posedge clk);
      #1; check("sh_sticky", {29'd0, fault}, 1);
      #1; rst = 1'b1;
      #1; check("sh_rst", {29'd0, fault}, 0);
      repeat (2) @(posedge clk);
      #2; rst = 1'b0;
`endif

      repeat (5) @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_duty_capture.md
# pwm_duty_capture

Three-phase PWM duty-cycle capture unit: the receiving end of the SPWM gate-signal path. It samples the phase A/B/C gate signals from the inverter modulator (or an external pin loop-back) and measures the period and high time of every carrier cycle in system clocks. It publishes one measurement per phase per period with a valid strobe, for closed-loop checking of the modulator and for board bring-up.

## Interface
Parameters:
- CNT_W, 16, width of the period and high-time counters and result words.
- FAULT_CYC, 4, number of consecutive synchronized cycles with both legs high that raises a shoot-through fault (only with the configuration macro).

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  reset: asynchronous assertion, active-high. It clears every register.
- pwm_a, pwm_b, pwm_c  in  1 each  asynchronous gate signals (Va, Vb, Vc).
- pwm_an, pwm_bn, pwm_cn  in  1 each  complementary gate signals. These ports exist only when PWM_CAP_SHOOT_CHECK_EN is defined.
- period_a, period_b, period_c  out  CNT_W each  last measured period in clks.
- high_a, high_b, high_c  out  CNT_W each  last measured high time in clks.
- valid  out  3  one-cycle strobe per phase: bit0 = A, bit1 = B, bit2 = C.
- stuck  out  3  per phase: no rising edge seen within 2^CNT_W-1 clks.
- fault  out  3  sticky shoot-through flag per phase. Constant 0 without the macro.

## Operation
- Synchronizer:
  - Each input passes through a 2-FF synchronizer (s1 → s2), then a delay register s_d.
  - rise = s2 & ~s_d.
- Per-channel state:
  - armed (1b), pcnt and hcnt (CNT_W each), output registers.
- Cycle behaviour, no rise:
  - pcnt ← pcnt+1, saturating at all-ones.
  - hcnt ← hcnt + s2, saturating.
- Cycle behaviour, rise:
  - If armed and not stuck: period ← pcnt, high ← hcnt, and valid pulses.
  - Then pcnt ← 1 and hcnt ← 1. The rise cycle itself is high and counts toward both.
  - armed ← 1 and stuck ← 0.
- First rise after reset (armed=0): the channel arms only. There is no valid strobe and the outputs keep their value.
- Saturation:
  - When pcnt reaches all-ones without a rise, stuck ← 1 and armed ← 0.
  - The period and high outputs hold their last value.
  - The next rise re-arms without a strobe, so a truncated period is never reported.
- Results: high ≤ period always. 0 % duty never produces a rise, so it shows up as stuck. 100 % duty likewise shows up as stuck.
- Channels are fully independent. Simultaneous rises on several phases give simultaneous valid bits.

## Timing
- Reset values:
  - period_*, high_*, valid, stuck, fault: 0.
  - armed, pcnt, hcnt: 0.
  - Synchronizer flops: 0.
- Latency: an input rising edge set up before clk edge k gives valid and updated outputs from edge k+3 (s1@k, s2@k+1, s_d@k+2, outputs@k+3). The result is therefore visible 3 clks after the edge.
- valid is high for exactly one clk. period and high stay stable until the next strobe.
- Minimum measurable pulse: 1 clk high or low after synchronization. Shorter glitches may be lost; this is legal.
- Reset mid-period: everything clears immediately (asynchronously). After release, the first rise arms only.
- Period measurement jitter: ±1 clk from input synchronization.

## Configuration
- PWM_CAP_SHOOT_CHECK_EN defined:
  - The pwm_*n inputs are present and synchronized the same way as the main inputs.
  - A per-phase counter increments while both s2 legs are high. It clears to 0 otherwise.
  - When the counter reaches FAULT_CYC, fault[x] ← 1 and stays set until rst.
  - Fault does not affect the measurements.
- Macro undefined: the pwm_*n ports and fault logic are absent, and fault is tied to 3'b000.

## Structure
- Package pwm_cap_pkg: default CNT_W, default FAULT_CYC, SYNC_STAGES = 2, and the phase index constants PH_A = 0, PH_B = 1, PH_C = 2.
- Sub-module pwm_capture_ch: one channel containing the synchronizer, edge detect, counters, arm/stuck logic and optional shoot-through counter. It is instantiated three times by pwm_duty_capture.

## Test plan
- Phase A square wave with 100-clk period and 30 clks high, steady: the first edge produces no strobe. Every following edge gives valid[0] 3 clks after the edge, period_a = 100, high_a = 30 (±1).
- A, B, C at 200/50, 200/100, 200/150 with identical edge times: valid = 3'b111 in the same cycle. Outputs are 200/50, 200/100, 200/150.
- Phase B held low for 2^CNT_W clks after running (CNT_W = 8 for the test): stuck[1] = 1 and outputs unchanged. The next rise gives no strobe, the following one a correct strobe, and stuck clears at the first rise.
- Assert rst mid-period while running at 100/30: all outputs are 0 immediately. After release, the first valid comes on the second rise with 100/30.
- PWM_CAP_SHOOT_CHECK_EN with FAULT_CYC = 4: overlap of 3 clks on A/An leaves fault = 0. Overlap of 4 clks gives fault[0] = 1, which stays set after the overlap ends until rst.
- Macro undefined: fault stays 3'b000 for any stimulus.
